// File: rtl/fsm_reg_pkg.sv
// -----------------------------------------------------------------------------
// fsm_reg_pkg
//   Shared definitions for the FSM register family.
//   - mode_e         : 3-bit operation select used by the state-register blocks
//   - MODE_W         : width of the mode field
//   - mode_is_count  : true for the modes that behave as an up/down counter
// -----------------------------------------------------------------------------
package fsm_reg_pkg;

    localparam int MODE_W = 3;

    // Operation encodings. Future FSM blocks must keep these values stable
    // because software and other blocks decode them directly.
    typedef enum logic [MODE_W-1:0] {
        MODE_HOLD  = 3'b000,
        MODE_LOAD  = 3'b001,
        MODE_SHL   = 3'b010,
        MODE_SHR   = 3'b011,
        MODE_INC   = 3'b100,
        MODE_DEC   = 3'b101,
        MODE_INV   = 3'b110,
        MODE_CLEAR = 3'b111
    } mode_e;

    // Counter modes are the only ones that can raise the wrap flag.
    function automatic logic mode_is_count(input mode_e m);
        return (m == MODE_INC) || (m == MODE_DEC);
    endfunction

endpackage : fsm_reg_pkg

// File: rtl/fsm_dff_cell.sv
// -----------------------------------------------------------------------------
// fsm_dff_cell
//   One bit of storage: a D flip-flop with asynchronous active-low reset to
//   the RESET_VAL parameter.
//   Ports:
//     clk   - clock, rising edge
//     rst_n - asynchronous active-low reset, forces q to RESET_VAL
//     d     - next value
//     q     - stored value
//     nq    - complement of q (derived, not a second flop)
// -----------------------------------------------------------------------------
module fsm_dff_cell #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic nq
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_VAL;
        end else begin
            q <= d;
        end
    end

    // Derived from q so it tracks q during reset as well.
    assign nq = ~q;

endmodule : fsm_dff_cell

// File: rtl/fsm_state_reg.sv
// -----------------------------------------------------------------------------
// fsm_state_reg
//   Multi-mode state register: hold, parallel load, shift left/right, count
//   up/down, invert and synchronous clear. Two registered status flags report
//   whether the value changed and whether the counter wrapped at the last edge.
//
//   Parameters:
//     WIDTH     - register width in bits, legal range 2..32
//     RESET_VAL - value loaded by rst_n and by MODE_CLEAR
//
//   Ports:
//     clk     - clock, all state changes on the rising edge
//     rst_n   - asynchronous active-low reset
//     mode    - operation select (fsm_reg_pkg::mode_e), sampled every edge
//     d       - parallel load data
//     sin_r   - serial input entering bit 0 on SHL
//     sin_l   - serial input entering bit WIDTH-1 on SHR
//     q       - registered state
//     nq      - bitwise complement of q
//     changed - 1 for the cycle after an edge that altered q
//     wrap    - 1 for the cycle after an INC F..F->0 or DEC 0->F..F edge
//
//   All outputs come straight from the storage cells, so there is no
//   combinational path from any input to any output.
// -----------------------------------------------------------------------------
module fsm_state_reg
    import fsm_reg_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_r,
    input  logic             sin_l,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] nq,
    output logic             changed,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    // Storage layout: [WIDTH-1:0] = q, [WIDTH] = changed, [WIDTH+1] = wrap.
    localparam int               NCELLS   = WIDTH + 2;
    localparam logic [NCELLS-1:0] CELL_RST = {2'b00, RESET_VAL};

    logic [WIDTH-1:0]  q_next;
    logic              changed_next;
    logic              wrap_next;
    logic [NCELLS-1:0] cell_d;
    logic [NCELLS-1:0] cell_q;
    logic [NCELLS-1:0] cell_nq;
    mode_e             mode_sel;

    assign mode_sel = mode_e'(mode);

    // -------------------------------------------------------------------------
    // Next-state multiplexer, indexed by mode. Each mode acts on the current
    // registered q, so consecutive different modes chain edge after edge.
    // -------------------------------------------------------------------------
    always_comb begin
        q_next    = q;
        wrap_next = 1'b0;
        case (mode_sel)
            MODE_HOLD:  q_next = q;
            MODE_LOAD:  q_next = d;
            MODE_SHL:   q_next = {q[WIDTH-2:0], sin_r};
            MODE_SHR:   q_next = {sin_l, q[WIDTH-1:1]};
            MODE_INC: begin
                q_next    = q + ONE;
                wrap_next = (q == ALL_ONES);
            end
            MODE_DEC: begin
                q_next    = q - ONE;
                wrap_next = (q == ALL_ZERO);
            end
            MODE_INV:   q_next = ~q;
            MODE_CLEAR: q_next = RESET_VAL;
            default:    q_next = q;
        endcase
    end

    // Compared against the value actually held, so LOAD of the same value or
    // CLEAR while already at RESET_VAL reports no change.
    assign changed_next = (q_next != q);

    assign cell_d = {wrap_next, changed_next, q_next};

    // -------------------------------------------------------------------------
    // Storage: one cell per bit of q plus one each for the two flags. The flag
    // cells reset to 0, the q cells to the matching bit of RESET_VAL.
    // -------------------------------------------------------------------------
    for (genvar i = 0; i < NCELLS; i++) begin : g_cell
        fsm_dff_cell #(
            .RESET_VAL (CELL_RST[i])
        ) u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (cell_d[i]),
            .q     (cell_q[i]),
            .nq    (cell_nq[i])
        );
    end

    assign q       = cell_q[WIDTH-1:0];
    assign nq      = cell_nq[WIDTH-1:0];
    assign changed = cell_q[WIDTH];
    assign wrap    = cell_q[WIDTH+1];

    // The flag cells' complement outputs have no consumer.
    logic unused_flag_nq;
    assign unused_flag_nq = ^cell_nq[NCELLS-1:WIDTH];

endmodule : fsm_state_reg

// File: tb/tb_fsm_state_reg.sv
// -----------------------------------------------------------------------------
// tb_fsm_state_reg
//   Directed and random stimulus for fsm_state_reg (WIDTH=4). A second
//   instance with RESET_VAL=4'hA shares the inputs and is only examined while
//   rst_n is low. Expected {q, changed, wrap} triples are produced by a small
//   reference model, queued when the inputs are driven and popped after the
//   following rising edge.
// -----------------------------------------------------------------------------
module tb_fsm_state_reg;

    localparam int W  = 4;
    localparam int EW = W + 2;   // packed {q, changed, wrap}

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [2:0]   mode;
    logic [W-1:0] d;
    logic         sin_r;
    logic         sin_l;

    logic [W-1:0] q,   nq;
    logic         changed, wrap;
    logic [W-1:0] q_a, nq_a;
    logic         changed_a, wrap_a;

    fsm_state_reg #(.WIDTH(W), .RESET_VAL(4'h0)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .mode    (mode),
        .d       (d),
        .sin_r   (sin_r),
        .sin_l   (sin_l),
        .q       (q),
        .nq      (nq),
        .changed (changed),
        .wrap    (wrap)
    );

    fsm_state_reg #(.WIDTH(W), .RESET_VAL(4'hA)) dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .mode    (mode),
        .d       (d),
        .sin_r   (sin_r),
        .sin_l   (sin_l),
        .q       (q_a),
        .nq      (nq_a),
        .changed (changed_a),
        .wrap    (wrap_a)
    );

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    logic [EW-1:0] exp_q[$];
    logic [W-1:0]  m_q;          // reference model of q
    int            vectors     = 0;
    int            miscompares = 0;
    logic          nq_watch_on = 1'b0;

    localparam logic [2:0] HOLD = 3'b000, LOAD = 3'b001, SHL = 3'b010, SHR = 3'b011;
    localparam logic [2:0] INC  = 3'b100, DEC  = 3'b101, INV = 3'b110, CLR = 3'b111;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model of one edge.
    function automatic logic [W-1:0] model_next(input logic [2:0] m, input logic [W-1:0] cur,
                                                 input logic [W-1:0] dv, input logic sr,
                                                 input logic sl);
        case (m)
            3'd0: return cur;
            3'd1: return dv;
            3'd2: return {cur[W-2:0], sr};
            3'd3: return {sl, cur[W-1:1]};
            3'd4: return cur + 4'd1;
            3'd5: return cur - 4'd1;
            3'd6: return ~cur;
            default: return 4'h0;
        endcase
    endfunction

    // Push the expected outcome of the edge about to happen with the current inputs.
    task automatic push_exp();
        logic [W-1:0] nxt;
        logic         c, w;
        nxt = model_next(mode, m_q, d, sin_r, sin_l);
        c   = (nxt != m_q);
        w   = (mode == INC && m_q == 4'hF) || (mode == DEC && m_q == 4'h0);
        exp_q.push_back({nxt, c, w});
        m_q = nxt;
    endtask

    task automatic pop_check(input string tag);
        logic [EW-1:0] e;
        if (exp_q.size() == 0) begin
            check({tag, " queue empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check(tag, {26'd0, q, changed, wrap}, {26'd0, e});
        end
    endtask

    // Driver: present inputs on the falling edge, check after the rising edge.
    task automatic step(input string tag, input logic [2:0] m, input logic [W-1:0] dv,
                        input logic sr, input logic sl);
        @(negedge clk);
        mode  = m;
        d     = dv;
        sin_r = sr;
        sin_l = sl;
        push_exp();
        @(posedge clk);
        #1;
        pop_check(tag);
    endtask

    // nq must mirror q at all times, reset included.
    always @(negedge clk) begin
        if (nq_watch_on) check("nq_track", {28'd0, nq}, {28'd0, ~q});
    end

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        mode  = HOLD;
        d     = '0;
        sin_r = 1'b0;
        sin_l = 1'b0;
        rst_n = 1'b1;
        m_q   = 4'h0;
        #1 rst_n = 1'b0;
        #2;
        check("por_q",       {28'd0, q},  32'h0);
        check("por_nq",      {28'd0, nq}, 32'hF);
        check("por_changed", {31'd0, changed}, 32'd0);
        check("por_wrap",    {31'd0, wrap},    32'd0);
        repeat (2) @(negedge clk);
        rst_n       = 1'b1;
        nq_watch_on = 1'b1;

        // Load and shift
        step("load_9", LOAD, 4'h9, 1'b0, 1'b0);
        step("shl_1",  SHL,  4'h0, 1'b1, 1'b0);
        step("shr_1",  SHR,  4'h0, 1'b0, 1'b1);

        // Reset pulse between edges, with changed previously 1
        @(negedge clk);
        mode = HOLD;
        #2 rst_n = 1'b0;
        #1;
        check("rst_q",       {28'd0, q},  32'h0);
        check("rst_nq",      {28'd0, nq}, 32'hF);
        check("rst_changed", {31'd0, changed}, 32'd0);
        check("rst_wrap",    {31'd0, wrap},    32'd0);
        check("rstA_q",      {28'd0, q_a},  32'hA);
        check("rstA_nq",     {28'd0, nq_a}, 32'h5);
        check("rstA_flags",  {30'd0, changed_a, wrap_a}, 32'd0);
        #1 rst_n = 1'b1;
        m_q = 4'h0;

        // First operation after reset: DEC from RESET_VAL wraps
        step("dec_from_rst", DEC, 4'h0, 1'b0, 1'b0);

        // Counter wrap
        step("load_E",  LOAD, 4'hE, 1'b0, 1'b0);
        step("inc_F",   INC,  4'h0, 1'b0, 1'b0);
        step("inc_0",   INC,  4'h0, 1'b0, 1'b0);
        step("dec_F",   DEC,  4'h0, 1'b0, 1'b0);
        step("hold_F",  HOLD, 4'h0, 1'b0, 1'b0);

        // Changed flag
        step("load_5a", LOAD, 4'h5, 1'b0, 1'b0);
        step("load_5b", LOAD, 4'h5, 1'b0, 1'b0);
        step("hold_5",  HOLD, 4'h0, 1'b0, 1'b0);
        step("inv_A",   INV,  4'h0, 1'b0, 1'b0);
        step("clr_a",   CLR,  4'h0, 1'b0, 1'b0);
        step("clr_b",   CLR,  4'h0, 1'b0, 1'b0);

        // Reset coincident with an INC edge
        step("load_7",  LOAD, 4'h7, 1'b0, 1'b0);
        @(negedge clk);
        mode = INC;
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_q",     {28'd0, q}, 32'h0);
        check("midrst_flags", {30'd0, changed, wrap}, 32'd0);
        m_q = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
        push_exp();
        @(posedge clk);
        #1;
        pop_check("post_rst_inc");

        // Random run
        for (int i = 0; i < 1000; i++) begin
            step("rand", 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        check("queue_drained", exp_q.size(), 32'd0);
        nq_watch_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_fsm_state_reg
